// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and stall/flush patterns for the hazard controller
package hazard_pkg;

  // Controller state: normal issue, divide occupying EX, data-cache miss in MEM
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DIV_BUSY = 2'd1,
    MISS     = 2'd2
  } hz_state_t;

  localparam int DIV_LAT_DEF = 8;

  // Pattern bit order for both bubble and flush vectors: {F, D, E, M, W}
  localparam logic [4:0] BUB_MISS  = 5'b11110;
  localparam logic [4:0] FL_MISS   = 5'b00001;
  localparam logic [4:0] BUB_DIV   = 5'b11100;
  localparam logic [4:0] FL_DIV    = 5'b00010;
  localparam logic [4:0] BUB_LU    = 5'b11000;
  localparam logic [4:0] FL_LU     = 5'b00100;
  localparam logic [4:0] FL_REDIR  = 5'b01100;
  localparam logic [4:0] FL_JAL    = 5'b01000;
  localparam logic [4:0] FL_RST    = 5'b01111;

endpackage

// File: rtl/hazard_div_timer.sv
// rtl/hazard_div_timer.sv - divide occupancy countdown and completion decode
module hazard_div_timer
  import hazard_pkg::*;
#(
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  input  logic i_hold,
  output logic o_active,
  output logic o_busy,
  output logic o_done
);

  logic [CNT_W-1:0] r_cnt;

  // Load on divide accept; count down, but park at 1 while a miss holds the result in EX
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CNT_W'(DIV_LAT - 1);
    end else if ((r_cnt > CNT_W'(1)) || ((r_cnt == CNT_W'(1)) && !i_hold)) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_active = (r_cnt != '0);
  assign o_busy   = (r_cnt > CNT_W'(1));
  assign o_done   = (r_cnt == CNT_W'(1)) && !i_hold && !rst;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller; HAZARD_PERF_EN enables perf counters
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs1_D,
  input  logic [4:0]  rs2_D,
  input  logic        rs1_used_D,
  input  logic        rs2_used_D,
  input  logic [4:0]  rd_E,
  input  logic        mem_read_E,
  input  logic        div_E,
  input  logic        br_mispredict_E,
  input  logic        jalr_E,
  input  logic        jal_D,
  input  logic        dmiss_M,
  output logic        bubbleF,
  output logic        bubbleD,
  output logic        bubbleE,
  output logic        bubbleM,
  output logic        bubbleW,
  output logic        flushF,
  output logic        flushD,
  output logic        flushE,
  output logic        flushM,
  output logic        flushW,
  output logic        div_done,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events
);

  hz_state_t  r_state;
  hz_state_t  w_next;
  hz_state_t  w_eff;
  logic [4:0] w_bub;
  logic [4:0] w_fl;
  logic       w_load;
  logic       w_lower;
  logic       w_active;
  logic       w_busy;
  logic       w_done;
  logic       w_redirect;
  logic       w_load_use;

  hazard_div_timer #(
    .DIV_LAT (DIV_LAT),
    .CNT_W   (CNT_W)
  ) u_div_timer (
    .clk      (clk),
    .rst      (rst),
    .i_load   (w_load),
    .i_hold   (dmiss_M),
    .o_active (w_active),
    .o_busy   (w_busy),
    .o_done   (w_done)
  );

  assign w_redirect = br_mispredict_E | jalr_E;
  assign w_load_use = mem_read_E && (rd_E != 5'd0) &&
                      ((rs1_used_D && (rs1_D == rd_E)) || (rs2_used_D && (rs2_D == rd_E)));

  // Hazard priority: miss, divide occupancy, redirect, load-use, jal; miss exit acts as its target state
  always_comb begin
    w_bub   = '0;
    w_fl    = '0;
    w_load  = 1'b0;
    w_lower = 1'b0;
    w_next  = r_state;
    w_eff   = r_state;
    if ((r_state == MISS) && !dmiss_M) begin
      w_eff = w_active ? DIV_BUSY : RUN;
    end
    if (rst) begin
      w_fl   = FL_RST;
      w_next = RUN;
    end else if (dmiss_M) begin
      w_bub  = BUB_MISS;
      w_fl   = FL_MISS;
      w_next = MISS;
    end else begin
      w_next = RUN;
      case (w_eff)
        DIV_BUSY: begin
          if (w_busy) begin
            w_bub  = BUB_DIV;
            w_fl   = FL_DIV;
            w_next = DIV_BUSY;
          end else begin
            w_lower = 1'b1;
          end
        end
        default: begin
          if (div_E) begin
            w_bub  = BUB_DIV;
            w_fl   = FL_DIV;
            w_load = 1'b1;
            w_next = DIV_BUSY;
          end else begin
            w_lower = 1'b1;
          end
        end
      endcase
      if (w_lower) begin
        if (w_redirect) begin
          w_fl = FL_REDIR;
        end else if (w_load_use) begin
          w_bub = BUB_LU;
          w_fl  = FL_LU;
        end else if (jal_D) begin
          w_fl = FL_JAL;
        end
      end
    end
  end

  // State register; reset aborts any divide or miss in progress
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_next;
    end
  end

  // A redirect can never legally accompany a divide entering EX
  always_ff @(posedge clk) begin
    if (!rst && w_load) begin
      assert (!w_redirect) else $error("hazard_ctrl: redirect coincides with divide entry");
    end
  end

  assign {bubbleF, bubbleD, bubbleE, bubbleM, bubbleW} = w_bub;
  assign {flushF, flushD, flushE, flushM, flushW}      = w_fl;
  assign div_done = w_done;

`ifdef HAZARD_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_events;

  // Stall cycles count any bubble; flush events count flushD outside reset (redirect or jal only)
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      if (|w_bub) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (w_fl[3]) r_flush_events <= r_flush_events + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;
`else
  assign stall_cycles = 32'd0;
  assign flush_events = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed table and sequence checks for hazard_ctrl
module tb_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1_D, rs2_D, rd_E;
  logic        rs1_used_D, rs2_used_D, mem_read_E, div_E;
  logic        br_mispredict_E, jalr_E, jal_D, dmiss_M;
  logic        bubbleF, bubbleD, bubbleE, bubbleM, bubbleW;
  logic        flushF, flushD, flushE, flushM, flushW;
  logic        div_done;
  logic [31:0] stall_cycles, flush_events;

  int checks;
  int failures;

  typedef struct {
    logic       r;
    logic [4:0] s1;
    logic [4:0] s2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       br;
    logic       jr;
    logic       jl;
    logic       dm;
    logic [4:0] eb;
    logic [4:0] ef;
    logic       ed;
  } vec_t;

  vec_t vecs[$];

  hazard_ctrl #(.DIV_LAT(8), .CNT_W(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .rs1_D           (rs1_D),
    .rs2_D           (rs2_D),
    .rs1_used_D      (rs1_used_D),
    .rs2_used_D      (rs2_used_D),
    .rd_E            (rd_E),
    .mem_read_E      (mem_read_E),
    .div_E           (div_E),
    .br_mispredict_E (br_mispredict_E),
    .jalr_E          (jalr_E),
    .jal_D           (jal_D),
    .dmiss_M         (dmiss_M),
    .bubbleF         (bubbleF),
    .bubbleD         (bubbleD),
    .bubbleE         (bubbleE),
    .bubbleM         (bubbleM),
    .bubbleW         (bubbleW),
    .flushF          (flushF),
    .flushD          (flushD),
    .flushE          (flushE),
    .flushM          (flushM),
    .flushW          (flushW),
    .div_done        (div_done),
    .stall_cycles    (stall_cycles),
    .flush_events    (flush_events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [4:0] s1, input logic [4:0] s2,
                     input logic u1, input logic u2, input logic [4:0] rd, input logic mr,
                     input logic br, input logic jr, input logic jl, input logic dm,
                     input logic [4:0] eb, input logic [4:0] ef, input logic ed);
    vec_t v;
    v.r = r; v.s1 = s1; v.s2 = s2; v.u1 = u1; v.u2 = u2; v.rd = rd; v.mr = mr;
    v.br = br; v.jr = jr; v.jl = jl; v.dm = dm; v.eb = eb; v.ef = ef; v.ed = ed;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    rst = 1'b0; rs1_D = 5'd0; rs2_D = 5'd0; rs1_used_D = 1'b0; rs2_used_D = 1'b0;
    rd_E = 5'd0; mem_read_E = 1'b0; div_E = 1'b0; br_mispredict_E = 1'b0;
    jalr_E = 1'b0; jal_D = 1'b0; dmiss_M = 1'b0;
  endtask

  task automatic set_load_use();
    rd_E = 5'd5; mem_read_E = 1'b1; rs1_D = 5'd5; rs1_used_D = 1'b1;
  endtask

  task automatic check(input string nm, input int idx, input logic [4:0] eb,
                       input logic [4:0] ef, input logic ed);
    logic [4:0] ab, af;
    ab = {bubbleF, bubbleD, bubbleE, bubbleM, bubbleW};
    af = {flushF, flushD, flushE, flushM, flushW};
    checks++;
    if (ab !== eb || af !== ef || div_done !== ed) begin
      failures++;
      $display("FAIL %s[%0d] got bubble=%b flush=%b div_done=%b expected bubble=%b flush=%b div_done=%b",
               nm, idx, ab, af, div_done, eb, ef, ed);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    #1;
    check("reset", 0, 5'b00000, 5'b01111, 1'b0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    idle_inputs();

    //   r  s1 s2 u1 u2 rd mr br jr jl dm  bubble    flush     done
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b01111, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0);
    add(0, 5, 0, 1, 0, 5, 1, 0, 0, 0, 0, 5'b11000, 5'b00100, 0);
    add(0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 5'b00000, 5'b00000, 0);
    add(0, 3, 7, 1, 1, 7, 1, 0, 0, 0, 0, 5'b11000, 5'b00100, 0);
    add(0, 7, 0, 0, 0, 7, 1, 0, 0, 0, 0, 5'b00000, 5'b00000, 0);
    add(0, 7, 0, 1, 0, 7, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0);
    add(0, 5, 0, 1, 0, 5, 1, 1, 0, 0, 0, 5'b00000, 5'b01100, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5'b00000, 5'b01100, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 5'b00000, 5'b01000, 0);
    add(0, 5, 0, 1, 0, 5, 1, 0, 0, 1, 0, 5'b11000, 5'b00100, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 5'b00000, 5'b01100, 0);
    add(0, 5, 0, 1, 0, 5, 1, 1, 0, 0, 1, 5'b11110, 5'b00001, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5'b11110, 5'b00001, 0);
    add(0, 5, 0, 1, 0, 5, 1, 0, 0, 0, 0, 5'b11000, 5'b00100, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00000, 5'b00000, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].r; rs1_D = vecs[i].s1; rs2_D = vecs[i].s2;
      rs1_used_D = vecs[i].u1; rs2_used_D = vecs[i].u2; rd_E = vecs[i].rd;
      mem_read_E = vecs[i].mr; div_E = 1'b0; br_mispredict_E = vecs[i].br;
      jalr_E = vecs[i].jr; jal_D = vecs[i].jl; dmiss_M = vecs[i].dm;
      #1;
      check("vec", i, vecs[i].eb, vecs[i].ef, vecs[i].ed);
    end

    // Plain divide: 7 stall cycles, done on 8, RUN on 9 (jal at cycle 4 is suppressed)
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      idle_inputs();
      div_E = (k <= 8);
      jal_D = (k == 4) || (k == 9);
      #1;
      if (k <= 7)       check("div", k, 5'b11100, 5'b00010, 1'b0);
      else if (k == 8)  check("div", k, 5'b00000, 5'b00000, 1'b1);
      else              check("div", k, 5'b00000, 5'b01000, 1'b0);
    end

    // Divide with a miss over cycles 3..12: completion lands on the miss exit cycle
    do_reset();
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      idle_inputs();
      div_E = (k <= 13);
      dmiss_M = (k >= 3) && (k <= 12);
      #1;
      if (k <= 2)        check("divmiss", k, 5'b11100, 5'b00010, 1'b0);
      else if (k <= 12)  check("divmiss", k, 5'b11110, 5'b00001, 1'b0);
      else if (k == 13)  check("divmiss", k, 5'b00000, 5'b00000, 1'b1);
      else               check("divmiss", k, 5'b00000, 5'b00000, 1'b0);
    end

    // Reset while DIV_BUSY with cnt=4: divide aborted, never completes
    do_reset();
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      idle_inputs();
      div_E = (k <= 5);
      rst = (k == 5);
      if (k == 6) set_load_use();
      #1;
      if (k <= 4)       check("divrst", k, 5'b11100, 5'b00010, 1'b0);
      else if (k == 5)  check("divrst", k, 5'b00000, 5'b01111, 1'b0);
      else if (k == 6)  check("divrst", k, 5'b11000, 5'b00100, 1'b0);
      else              check("divrst", k, 5'b00000, 5'b00000, 1'b0);
    end

    // Perf counters: 3 load-use stalls and 2 redirects after reset
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      idle_inputs();
      if (k <= 3) set_load_use();
      if (k == 4) br_mispredict_E = 1'b1;
      if (k == 5) jalr_E = 1'b1;
      #1;
    end
    checks++;
`ifdef HAZARD_PERF_EN
    if (stall_cycles !== 32'd3 || flush_events !== 32'd2) begin
      failures++;
      $display("FAIL perf got stall=%0d flush=%0d expected stall=3 flush=2", stall_cycles, flush_events);
    end
`else
    if (stall_cycles !== 32'd0 || flush_events !== 32'd0) begin
      failures++;
      $display("FAIL perf got stall=%0d flush=%0d expected stall=0 flush=0", stall_cycles, flush_events);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
